matvec_ctrl: RTL and testbench

- Control FSM for the matrix-vector multiplier datapath: matrix memory, vector memory, single multiply-accumulate unit, output register.
- Accepts the 14-bit input word stream handshake and the new_matrix flag; generates memory write/read addresses, MAC clear/enable and output_valid.
- Sits between the top-level valid/ready ports and the datapath; carries no data bits itself.
- Sequences one M x N matrix times N-vector problem at a time; the matrix is reused when new_matrix=0.

---
 rtl/matvec_ctrl_if.sv | 25 ++
 rtl/matvec_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_matvec_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/matvec_ctrl_if.sv
// Stream handshake between upstream/downstream ports and the matrix-vector controller.
// master drives words and accepts results; slave is the controller.
interface matvec_ctrl_if;
    logic input_valid;
    logic input_ready;
    logic new_matrix;
    logic output_valid;
    logic output_ready;

    modport master (
        output input_valid,
        output new_matrix,
        output output_ready,
        input  input_ready,
        input  output_valid
    );

    modport slave (
        input  input_valid,
        input  new_matrix,
        input  output_ready,
        output input_ready,
        output output_valid
    );
endinterface

// File: rtl/matvec_ctrl.sv
// Control FSM for an M x N matrix-vector multiplier: memory write/read addressing and MAC sequencing.
// Optional counters stall_cycles_o / problems_done_o are built when MATVEC_CTRL_PERF_EN is defined.
module matvec_ctrl #(
    parameter  int unsigned M       = 3,
    parameter  int unsigned N       = 3,
    parameter  int unsigned MAC_LAT = 1,
    localparam int unsigned AW_M    = (M * N > 1) ? $clog2(M * N) : 1,
    localparam int unsigned AW_X    = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              reset,
    matvec_ctrl_if.slave      hs_if,
    output logic              wr_en_m_o,
    output logic [AW_M-1:0]   wr_addr_m_o,
    output logic              wr_en_x_o,
    output logic [AW_X-1:0]   wr_addr_x_o,
    output logic [AW_M-1:0]   rd_addr_m_o,
    output logic [AW_X-1:0]   rd_addr_x_o,
    output logic              mac_en_o,
    output logic              mac_clear_o
`ifdef MATVEC_CTRL_PERF_EN
    ,
    output logic [15:0]       stall_cycles_o,
    output logic [15:0]       problems_done_o
`endif
);

    localparam int unsigned AW_R = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned AW_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_M,
        LOAD_X,
        COMPUTE,
        WAIT,
        OUTPUT
    } state_e;

    state_e            state_q, state_d;
    logic [AW_M-1:0]   m_cnt_q, m_cnt_d;
    logic [AW_X-1:0]   x_cnt_q, x_cnt_d;
    logic [AW_X-1:0]   col_q, col_d;
    logic [AW_R-1:0]   row_q, row_d;
    logic [AW_M-1:0]   rd_m_q, rd_m_d;
    logic [AW_W-1:0]   wait_q, wait_d;
    logic              mat_valid_q, mat_valid_d;
    logic              rdy_en_q;
    logic              in_rdy, out_vld, hs_in, hs_out, row_last;

    // rdy_en_q keeps input_ready low for the cycle following a sampled reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            m_cnt_q     <= '0;
            x_cnt_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            rd_m_q      <= '0;
            wait_q      <= '0;
            mat_valid_q <= 1'b0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_cnt_q     <= m_cnt_d;
            x_cnt_q     <= x_cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            rd_m_q      <= rd_m_d;
            wait_q      <= wait_d;
            mat_valid_q <= mat_valid_d;
            rdy_en_q    <= 1'b1;
        end
    end

    assign in_rdy   = rdy_en_q && (state_q == IDLE || state_q == LOAD_M || state_q == LOAD_X);
    assign out_vld  = (state_q == OUTPUT);
    assign hs_in    = hs_if.input_valid && in_rdy;
    assign hs_out   = out_vld && hs_if.output_ready;
    assign row_last = (row_q == AW_R'(M - 1));

    always_comb begin
        state_d     = state_q;
        m_cnt_d     = m_cnt_q;
        x_cnt_d     = x_cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        rd_m_d      = rd_m_q;
        wait_d      = wait_q;
        mat_valid_d = mat_valid_q;
        wr_en_m_o   = 1'b0;
        wr_en_x_o   = 1'b0;
        mac_en_o    = 1'b0;
        mac_clear_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (hs_in) begin
                    if (hs_if.new_matrix || !mat_valid_q) begin
                        // Starting a matrix load invalidates the stored matrix until it completes
                        wr_en_m_o   = 1'b1;
                        mat_valid_d = 1'b0;
                        if (M * N == 1) begin
                            mat_valid_d = 1'b1;
                            state_d     = LOAD_X;
                        end else begin
                            m_cnt_d = AW_M'(1);
                            state_d = LOAD_M;
                        end
                    end else begin
                        wr_en_x_o = 1'b1;
                        if (N == 1) begin
                            state_d = COMPUTE;
                        end else begin
                            x_cnt_d = AW_X'(1);
                            state_d = LOAD_X;
                        end
                    end
                end
            end
            LOAD_M: begin
                if (hs_in) begin
                    wr_en_m_o = 1'b1;
                    if (m_cnt_q == AW_M'(M * N - 1)) begin
                        m_cnt_d     = '0;
                        mat_valid_d = 1'b1;
                        state_d     = LOAD_X;
                    end else begin
                        m_cnt_d = m_cnt_q + AW_M'(1);
                    end
                end
            end
            LOAD_X: begin
                if (hs_in) begin
                    wr_en_x_o = 1'b1;
                    if (x_cnt_q == AW_X'(N - 1)) begin
                        x_cnt_d = '0;
                        state_d = COMPUTE;
                    end else begin
                        x_cnt_d = x_cnt_q + AW_X'(1);
                    end
                end
            end
            COMPUTE: begin
                mac_en_o    = 1'b1;
                mac_clear_o = (col_q == '0);
                rd_m_d      = (rd_m_q == AW_M'(M * N - 1)) ? '0 : rd_m_q + AW_M'(1);
                if (col_q == AW_X'(N - 1)) begin
                    col_d   = '0;
                    wait_d  = '0;
                    state_d = (MAC_LAT > 1) ? WAIT : OUTPUT;
                end else begin
                    col_d = col_q + AW_X'(1);
                end
            end
            WAIT: begin
                if (wait_q == AW_W'(MAC_LAT - 2)) begin
                    wait_d  = '0;
                    state_d = OUTPUT;
                end else begin
                    wait_d = wait_q + AW_W'(1);
                end
            end
            OUTPUT: begin
                if (hs_out) begin
                    if (row_last) begin
                        row_d   = '0;
                        state_d = IDLE;
                    end else begin
                        row_d   = row_q + AW_R'(1);
                        state_d = COMPUTE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hs_if.input_ready  = in_rdy;
    assign hs_if.output_valid = out_vld;
    assign wr_addr_m_o        = m_cnt_q;
    assign wr_addr_x_o        = x_cnt_q;
    assign rd_addr_m_o        = rd_m_q;
    assign rd_addr_x_o        = col_q;

`ifdef MATVEC_CTRL_PERF_EN
    logic [15:0] stall_q, stall_d;
    logic [15:0] done_q, done_d;

    // Stall counter saturates; problem counter wraps
    always_comb begin
        stall_d = stall_q;
        done_d  = done_q;
        if (out_vld && !hs_if.output_ready && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
        if (hs_out && row_last) begin
            done_d = done_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            done_q  <= '0;
        end else begin
            stall_q <= stall_d;
            done_q  <= done_d;
        end
    end

    assign stall_cycles_o  = stall_q;
    assign problems_done_o = done_q;
`endif

endmodule

// File: tb/tb_matvec_ctrl.sv
// Directed self-checking bench for matvec_ctrl (M=N=3, MAC_LAT=1); perf counters checked when MATVEC_CTRL_PERF_EN is defined.
module tb_matvec_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en_m, wr_en_x, mac_en, mac_clear;
    logic [3:0] wr_addr_m, rd_addr_m;
    logic [1:0] wr_addr_x, rd_addr_x;
`ifdef MATVEC_CTRL_PERF_EN
    logic [15:0] stall_cycles, problems_done;
`endif

    int n_asserts = 0;
    int n_fails   = 0;

    matvec_ctrl_if bus ();

    matvec_ctrl #(.M(3), .N(3), .MAC_LAT(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .hs_if       (bus.slave),
        .wr_en_m_o   (wr_en_m),
        .wr_addr_m_o (wr_addr_m),
        .wr_en_x_o   (wr_en_x),
        .wr_addr_x_o (wr_addr_x),
        .rd_addr_m_o (rd_addr_m),
        .rd_addr_x_o (rd_addr_x),
        .mac_en_o    (mac_en),
        .mac_clear_o (mac_clear)
`ifdef MATVEC_CTRL_PERF_EN
        ,
        .stall_cycles_o  (stall_cycles),
        .problems_done_o (problems_done)
`endif
    );

    always #5 clk = ~clk;

    // Drive inputs on the falling edge, then let combinational outputs settle
    task automatic cyc(input logic rst, input logic iv, input logic nm, input logic ordy);
        @(negedge clk);
        reset            = rst;
        bus.input_valid  = iv;
        bus.new_matrix   = nm;
        bus.output_ready = ordy;
        #1;
    endtask

    // Addresses are compared only where the matching enable is expected high
    task automatic expect_o(input string tag, input logic e_ir, input logic e_ov,
                            input logic e_wm, input logic e_wx, input logic e_mac, input logic e_clr,
                            input logic [3:0] e_am, input logic [1:0] e_ax,
                            input logic [3:0] e_rm, input logic [1:0] e_rx);
        logic [17:0] obs, exp;
        obs = {bus.input_ready, bus.output_valid, wr_en_m, wr_en_x, mac_en, mac_clear,
               e_wm ? wr_addr_m : 4'h0, e_wx ? wr_addr_x : 2'h0,
               e_mac ? rd_addr_m : 4'h0, e_mac ? rd_addr_x : 2'h0};
        exp = {e_ir, e_ov, e_wm, e_wx, e_mac, e_clr, e_am, e_ax, e_rm, e_rx};
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_m(input string tag, input int i, input logic nm);
        cyc(1'b0, 1'b1, nm, 1'b1);
        expect_o(tag, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'(i), 2'h0, 4'h0, 2'h0);
    endtask

    task automatic send_x(input string tag, input int i, input logic nm);
        cyc(1'b0, 1'b1, nm, 1'b1);
        expect_o(tag, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 2'(i), 4'h0, 2'h0);
    endtask

    task automatic compute_row(input string tag, input int r, input logic iv);
        for (int c = 0; c < 3; c++) begin
            cyc(1'b0, iv, 1'b0, 1'b1);
            expect_o(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (c == 0), 4'h0, 2'h0, 4'(r * 3 + c), 2'(c));
        end
    endtask

    task automatic out_cycle(input string tag, input logic iv, input logic ordy);
        cyc(1'b0, iv, 1'b0, ordy);
        expect_o(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'h0, 4'h0, 2'h0);
    endtask

    task automatic idle_chk(input string tag);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        expect_o(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'h0, 4'h0, 2'h0);
    endtask

    initial begin
        logic [7:0] ivpat;
        int         cnt;

        reset            = 1'b1;
        bus.input_valid  = 1'b0;
        bus.new_matrix   = 1'b0;
        bus.output_ready = 1'b0;

        // Reset: everything low, input_ready held low one extra cycle
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        expect_o("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'h0, 4'h0, 2'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        expect_o("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'h0, 4'h0, 2'h0);

        // Full problem with a new matrix, no backpressure
        for (int i = 0; i < 9; i++) send_m("s1_m", i, (i == 0) ? 1'b1 : 1'(i % 2));
        for (int i = 0; i < 3; i++) send_x("s1_x", i, 1'b1);
        for (int r = 0; r < 3; r++) begin
            compute_row("s1_mac", r, 1'b0);
            out_cycle("s1_out", 1'b0, 1'b1);
        end
        idle_chk("s1_idle");
`ifdef MATVEC_CTRL_PERF_EN
        n_asserts++;
        assert (problems_done === 16'd1) else begin
            n_fails++;
            $error("FAIL s1_done: observed %0d expected 1", problems_done);
        end
`endif

        // Matrix reuse; row 0 result stalled for 7 cycles
        for (int i = 0; i < 3; i++) send_x("s2_x", i, (i == 0) ? 1'b0 : 1'b1);
        compute_row("s2_mac", 0, 1'b0);
        repeat (7) out_cycle("s2_stall", 1'b0, 1'b0);
        out_cycle("s2_out", 1'b0, 1'b1);
        for (int r = 1; r < 3; r++) begin
            compute_row("s2_mac", r, 1'b0);
            out_cycle("s2_out", 1'b0, 1'b1);
        end
        idle_chk("s2_idle");
`ifdef MATVEC_CTRL_PERF_EN
        n_asserts++;
        assert (stall_cycles === 16'd7) else begin
            n_fails++;
            $error("FAIL s2_stall_cnt: observed %0d expected 7", stall_cycles);
        end
        n_asserts++;
        assert (problems_done === 16'd2) else begin
            n_fails++;
            $error("FAIL s2_done: observed %0d expected 2", problems_done);
        end
`endif

        // Gapped vector words; upstream keeps offering while busy
        ivpat = 8'b0110_0101;
        cnt   = 0;
        for (int k = 0; k < 8; k++) begin
            if (cnt < 3) begin
                cyc(1'b0, ivpat[k], 1'b0, 1'b1);
                if (ivpat[k]) begin
                    expect_o("s4_x", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 2'(cnt), 4'h0, 2'h0);
                    cnt++;
                end else begin
                    expect_o("s4_gap", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'h0, 4'h0, 2'h0);
                end
            end
        end
        compute_row("s4_mac", 0, 1'b1);
        out_cycle("s4_hold", 1'b1, 1'b0);
        out_cycle("s4_hold", 1'b1, 1'b0);
        out_cycle("s4_out", 1'b1, 1'b1);
        compute_row("s4_mac", 1, 1'b1);
        out_cycle("s4_out", 1'b1, 1'b1);
        compute_row("s4_mac", 2, 1'b1);
        out_cycle("s4_hold", 1'b1, 1'b0);
        out_cycle("s4_out", 1'b0, 1'b1);
        repeat (100) idle_chk("s4_quiet");

        // Abort a matrix load with reset, then a new_matrix=0 problem must reload
        for (int i = 0; i < 5; i++) send_m("s5_m", i, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        expect_o("s5_pre_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'h0, 4'h0, 2'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        expect_o("s5_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'h0, 4'h0, 2'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        expect_o("s5_post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'h0, 4'h0, 2'h0);
        for (int i = 0; i < 9; i++) send_m("s5_reload", i, (i == 0) ? 1'b0 : 1'b1);
        for (int i = 0; i < 3; i++) send_x("s5_x", i, 1'b0);
        for (int r = 0; r < 3; r++) begin
            compute_row("s5_mac", r, 1'b0);
            out_cycle("s5_out", 1'b0, 1'b1);
        end
        idle_chk("s5_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
